// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM state type and default width for the RV32M mul/div sequencer.
package muldiv_pkg;

  localparam int unsigned MULDIV_XLEN = 32;

  localparam logic [3:0] OP_NONE   = 4'b0000;
  localparam logic [3:0] OP_MUL    = 4'b0011;
  localparam logic [3:0] OP_MULH   = 4'b0101;
  localparam logic [3:0] OP_MULHU  = 4'b0111;
  localparam logic [3:0] OP_MULHSU = 4'b0110;
  localparam logic [3:0] OP_DIV    = 4'b1001;
  localparam logic [3:0] OP_DIVU   = 4'b1011;
  localparam logic [3:0] OP_REM    = 4'b1101;
  localparam logic [3:0] OP_REMU   = 4'b1111;

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} muldiv_state_t;

endpackage

// File: rtl/muldiv_div_step.sv
// One combinational restoring-division step: shifts the next dividend bit into the
// partial remainder and emits one quotient bit.
module muldiv_div_step
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = MULDIV_XLEN
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] dvsr,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0] partial;
  logic [XLEN:0] diff;

  always_comb begin
    partial = {rem_in, quo_in[XLEN-1]};
    diff    = partial - {1'b0, dvsr};
    // rem_in < dvsr keeps partial below 2^(XLEN+1), so the top bit of diff is the borrow
    if (!diff[XLEN]) begin
      rem_out = diff[XLEN-1:0];
      quo_out = {quo_in[XLEN-2:0], 1'b1};
    end else begin
      rem_out = partial[XLEN-1:0];
      quo_out = {quo_in[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// RV32M mul/div sequencer: one-cycle multiply, 32-step restoring divide, stall and flush.
// Optional divide result cache enabled by defining MULDIV_OPCACHE_EN.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN      = MULDIV_XLEN,
  parameter int unsigned DIV_STEPS = MULDIV_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [3:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic [4:0]      req_rd,
  input  logic            flush,
  output logic            stall,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_data,
  output logic [4:0]      resp_rd
);

  muldiv_state_t state, state_nxt;

  logic [3:0]        op_r;
  logic [4:0]        rd_r;
  logic [XLEN-1:0]   a_r, b_r, dvsr_r, quo_r, rem_r;
  logic [2*XLEN-1:0] prod_r;
  logic [5:0]        cnt_r;
  logic              neg_q_r, neg_r_r;

  logic              accept, in_sgn, a_neg, b_neg, b_zero, div_ovf;
  logic [XLEN-1:0]   a_mag, b_mag, quo_step, rem_step, quo_fix, rem_fix;
  logic [2*XLEN-1:0] mul_a, mul_b;
  logic              cache_hit;
  logic [XLEN-1:0]   hit_quo, hit_rem;

  always_comb begin
    in_sgn  = (req_op[1:0] == 2'b01);
    a_neg   = in_sgn & req_a[XLEN-1];
    b_neg   = in_sgn & req_b[XLEN-1];
    a_mag   = a_neg ? -req_a : req_a;
    b_mag   = b_neg ? -req_b : req_b;
    b_zero  = (req_b == '0);
    div_ovf = in_sgn & (req_a == {1'b1, {(XLEN-1){1'b0}}}) & (req_b == '1);
    accept  = (state == IDLE) & req_valid & ~flush & (req_op != OP_NONE);
  end

  // Sign-extending to 2*XLEN makes a plain modular multiply yield the exact signed product
  always_comb begin
    mul_a   = {{XLEN{(op_r[1:0] != 2'b11) & a_r[XLEN-1]}}, a_r};
    mul_b   = {{XLEN{(op_r[1:0] == 2'b01) & b_r[XLEN-1]}}, b_r};
    quo_fix = neg_q_r ? -quo_r : quo_r;
    rem_fix = neg_r_r ? -rem_r : rem_r;
  end

  muldiv_div_step #(.XLEN(XLEN)) u_step (
    .rem_in  (rem_r),
    .quo_in  (quo_r),
    .dvsr    (dvsr_r),
    .rem_out (rem_step),
    .quo_out (quo_step)
  );

`ifdef MULDIV_OPCACHE_EN
  logic            c_valid, c_sgn;
  logic [XLEN-1:0] c_a, c_b, c_quo, c_rem;

  assign cache_hit = c_valid & (c_a == req_a) & (c_b == req_b) & (c_sgn == in_sgn);
  assign hit_quo   = c_quo;
  assign hit_rem   = c_rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_valid <= 1'b0;
      c_sgn   <= 1'b0;
      c_a     <= '0;
      c_b     <= '0;
      c_quo   <= '0;
      c_rem   <= '0;
    end else if (flush || (accept && !req_op[3])) begin
      c_valid <= 1'b0;
    end else if (state == FIX) begin
      c_valid <= 1'b1;
      c_sgn   <= (op_r[1:0] == 2'b01);
      c_a     <= a_r;
      c_b     <= b_r;
      c_quo   <= quo_fix;
      c_rem   <= rem_fix;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign hit_quo   = '0;
  assign hit_rem   = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) begin
        if (!req_op[3])                      state_nxt = MUL;
        else if (b_zero || div_ovf || cache_hit) state_nxt = DONE;
        else                                 state_nxt = DIV;
      end
      MUL:  state_nxt = DONE;
      DIV:  if (cnt_r == '0) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r    <= '0;
      rd_r    <= '0;
      a_r     <= '0;
      b_r     <= '0;
      dvsr_r  <= '0;
      quo_r   <= '0;
      rem_r   <= '0;
      prod_r  <= '0;
      cnt_r   <= '0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          op_r    <= req_op;
          rd_r    <= req_rd;
          a_r     <= req_a;
          b_r     <= req_b;
          neg_q_r <= a_neg ^ b_neg;
          neg_r_r <= a_neg;
          if (req_op[3]) begin
            if (b_zero) begin
              quo_r <= '1;
              rem_r <= req_a;
            end else if (div_ovf) begin
              quo_r <= req_a;
              rem_r <= '0;
            end else if (cache_hit) begin
              quo_r <= hit_quo;
              rem_r <= hit_rem;
            end else begin
              quo_r  <= a_mag;
              rem_r  <= '0;
              dvsr_r <= b_mag;
              cnt_r  <= 6'(DIV_STEPS - 1);
            end
          end
        end
        MUL: prod_r <= mul_a * mul_b;
        DIV: begin
          quo_r <= quo_step;
          rem_r <= rem_step;
          cnt_r <= cnt_r - 6'd1;
        end
        FIX: begin
          quo_r <= quo_fix;
          rem_r <= rem_fix;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready  = (state == IDLE);
    stall      = (req_valid & (req_op != OP_NONE) & (state != IDLE)) |
                 ((state != IDLE) & (state != DONE));
    resp_valid = (state == DONE) & ~flush;
    resp_rd    = rd_r;
    if (op_r[3]) resp_data = op_r[2] ? rem_r : quo_r;
    else         resp_data = op_r[2] ? prod_r[2*XLEN-1:XLEN] : prod_r[XLEN-1:0];
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: stimulus pushes expected results, a monitor pops on resp_valid.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int DIV_LAT = 34;
`ifdef MULDIV_OPCACHE_EN
  localparam int HIT_LAT = 1;
`else
  localparam int HIT_LAT = 34;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [4:0]  req_rd = '0;
  logic        flush = 1'b0;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  muldiv_ctrl #(.XLEN(32), .DIV_STEPS(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_rd     (req_rd),
    .flush      (flush),
    .stall      (stall),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_rd    (resp_rd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every response must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_resp: got resp_valid=1 data=%h rd=%0d expected no response",
                 resp_data, resp_rd);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_data", {32'd0, resp_data}, {32'd0, e.data});
        check("resp_rd", {59'd0, resp_rd}, {59'd0, e.rd});
        check("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
      end
    end
  end

  // Called at #1 after a rising edge; returns #1 after the accept edge
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit want, input logic [31:0] exp,
                       input int lat);
    int t = 0;
    while (req_ready !== 1'b1 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (req_ready !== 1'b1) begin
      n_checks++;
      $display("FAIL ready_timeout: got req_ready=%b expected 1", req_ready);
      return;
    end
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_rd    = rd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op    = '0;
    if (want) sb.push_back('{exp, rd, cyc, lat});
  endtask

  task automatic wait_done();
    int t = 0;
    while ((sb.size() != 0 || req_ready !== 1'b1) && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (sb.size() != 0 || req_ready !== 1'b1) begin
      n_checks++;
      $display("FAIL done_timeout: got queue=%0d ready=%b expected empty queue and ready=1",
               sb.size(), req_ready);
      sb.delete();
    end
  endtask

  task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input logic [31:0] exp, input int lat);
    issue(op, a, b, rd, 1'b1, exp, lat);
    wait_done();
  endtask

  initial begin
    int bad;
    @(posedge clk); #1;
    check("rst_ready", {63'd0, req_ready}, 64'd1);
    check("rst_stall", {63'd0, stall}, 64'd0);
    check("rst_valid", {63'd0, resp_valid}, 64'd0);
    check("rst_data", {32'd0, resp_data}, 64'd0);
    check("rst_rd", {59'd0, resp_rd}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run(OP_MUL,    32'd7,        32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB, 2);
    run(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE, 2);
    run(OP_MULHSU, 32'hFFFFFFFF, 32'd2,        5'd3, 32'hFFFFFFFF, 2);
    run(OP_MULH,   32'h80000000, 32'h80000000, 5'd4, 32'h40000000, 2);
    run(OP_MULHU,  32'd7,        32'hFFFFFFFD, 5'd6, 32'h00000006, 2);

    issue(OP_DIV, 32'hFFFFFFEC, 32'd3, 5'd7, 1'b1, 32'hFFFFFFFA, DIV_LAT);
    bad = 0;
    repeat (33) begin
      @(negedge clk);
      if (stall !== 1'b1 || req_ready !== 1'b0) bad++;
    end
    check("stall_busy", 64'(bad), 64'd0);
    wait_done();
    run(OP_REM,  32'hFFFFFFEC, 32'd3,        5'd8,  32'hFFFFFFFE, HIT_LAT);
    run(OP_DIV,  32'd7,        32'hFFFFFFFE, 5'd9,  32'hFFFFFFFD, DIV_LAT);
    run(OP_REM,  32'd7,        32'hFFFFFFFE, 5'd10, 32'd1,        HIT_LAT);

    run(OP_DIVU, 32'd5,        32'd0,        5'd11, 32'hFFFFFFFF, 1);
    run(OP_REMU, 32'd5,        32'd0,        5'd12, 32'd5,        1);
    run(OP_REM,  32'hFFFFFFF9, 32'd0,        5'd13, 32'hFFFFFFF9, 1);
    run(OP_REM,  32'h80000000, 32'hFFFFFFFF, 5'd14, 32'd0,        1);
    run(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1);
    run(OP_DIVU, 32'hFFFFFFFF, 32'd2,        5'd16, 32'h7FFFFFFF, DIV_LAT);

    run(OP_DIVU, 32'd100, 32'd7, 5'd18, 32'd14, DIV_LAT);
    run(OP_REMU, 32'd100, 32'd7, 5'd19, 32'd2,  HIT_LAT);
    run(OP_DIV,  32'd100, 32'd7, 5'd20, 32'd14, DIV_LAT);
    run(OP_MUL,  32'd3,   32'd5, 5'd21, 32'd15, 2);
    run(OP_REMU, 32'd100, 32'd7, 5'd22, 32'd2,  DIV_LAT);

    // Reset in the middle of a divide: no response, clean restart
    issue(OP_DIVU, 32'd1000, 32'd3, 5'd23, 1'b0, 32'd0, 0);
    repeat (5) begin @(posedge clk); #1; end
    #1 rst = 1'b1;
    #1;
    check("midrst_ready", {63'd0, req_ready}, 64'd1);
    check("midrst_stall", {63'd0, stall}, 64'd0);
    check("midrst_data", {32'd0, resp_data}, 64'd0);
    check("midrst_rd", {59'd0, resp_rd}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run(OP_DIVU, 32'd100, 32'd7, 5'd17, 32'd14, DIV_LAT);

    // Flush in the middle of a divide
    issue(OP_DIV, 32'd50, 32'd5, 5'd24, 1'b0, 32'd0, 0);
    repeat (8) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_ready", {63'd0, req_ready}, 64'd1);
    check("flush_stall", {63'd0, stall}, 64'd0);
    run(OP_REMU, 32'd100, 32'd7, 5'd25, 32'd2,  DIV_LAT);
    run(OP_MUL,  32'd6,   32'd7, 5'd26, 32'd42, 2);

    // Flush sampled during the DONE cycle of a special-case divide
    issue(OP_DIVU, 32'd5, 32'd0, 5'd27, 1'b0, 32'd0, 0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_done_ready", {63'd0, req_ready}, 64'd1);

    // Flush alongside a request in IDLE: nothing accepted
    req_valid = 1'b1;
    req_op    = OP_MUL;
    req_a     = 32'd2;
    req_b     = 32'd2;
    req_rd    = 5'd28;
    flush     = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op    = '0;
    flush     = 1'b0;
    check("flush_no_accept", {63'd0, req_ready}, 64'd1);
    repeat (3) begin @(posedge clk); #1; end
    run(OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd29, 32'd1, 2);

    wait_done();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1);
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Multi-cycle sequencer for the RV32M mul/div unit in the execute stage.
- Accepts the decoder's 4-bit mulDiv_op code with two 32-bit operands.
- Multiplies in one compute cycle; divides by 32-step iterative restoring division.
- Raises a stall to the pipeline while busy, returns the result with the destination tag, and supports flush on exception.

Parameters:
- XLEN, 32, operand/result width.
- DIV_STEPS, 32, division iterations; must equal XLEN.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_op  in  4  mulDiv_op code: 0011 MUL, 0101 MULH, 0111 MULHU, 0110 MULHSU, 1001 DIV, 1011 DIVU, 1101 REM, 1111 REMU; 0000 is ignored.
- req_a, req_b  in  XLEN  rs1, rs2 values.
- req_rd  in  5  destination register tag.
- flush  in  1  kill the in-flight op (exception_pending from commit).
- stall  out  1  pipeline hold.
- resp_valid  out  1  one-cycle result pulse.
- resp_data  out  XLEN  result.
- resp_rd  out  5  tag of the op that produced resp_data.

Behaviour:
- Clock, reset and transfer:
  - One clock. Reset is asynchronous and active-high.
  - Reset state: IDLE. req_ready=1, stall=0, resp_valid=0, resp_data=0, resp_rd=0, all datapath registers 0.
  - Accept when req_valid & req_ready & ~flush & req_op!=0000. Operands, op and rd are latched at the accept edge.
- Op decoding:
  - op[3]: 1 = divide family. op[2]: 1 = high product / remainder.
  - op[1:0] sets signedness: 01 = both signed; 11 = both unsigned; 10 = a signed, b unsigned.
- States: IDLE, MUL, DIV, FIX, DONE.
  - IDLE -> MUL on an accepted multiply.
  - IDLE -> DIV on an accepted divide with b!=0 and no signed overflow.
  - IDLE -> DONE on a special-case divide.
  - MUL -> DONE: the signed 2*XLEN-bit product is registered. Result is low XLEN bits for MUL, high XLEN bits otherwise.
  - DIV: operands are converted to magnitudes at accept. One restoring step per cycle; a 6-bit counter counts down from DIV_STEPS-1. At count 0 -> FIX.
  - FIX: negate the quotient if operand signs differ (signed op). Negate the remainder if the dividend is negative (signed op). -> DONE.
  - DONE: resp_valid=1 for exactly one cycle, with resp_data/resp_rd valid. -> IDLE unconditionally.
- Latency (accept edge to resp_valid cycle):
  - MUL family: 2.
  - DIV/REM normal: DIV_STEPS+2 = 34.
  - Special cases: 1.
- Special cases:
  - b=0: DIV/DIVU result 0xFFFFFFFF; REM/REMU result = a.
  - Signed DIV/REM with a=0x80000000 and b=0xFFFFFFFF: quotient 0x80000000, remainder 0.
- Handshake and stall:
  - req_ready = (state==IDLE). No acceptance in DONE, so there is at least one idle cycle between ops.
  - stall = req_valid & (req_op!=0) & ~(state==IDLE) | (state!=IDLE & state!=DONE).
  - The pipeline holds until the resp_valid cycle.
- Flush:
  - flush is synchronous. Any non-IDLE state -> IDLE at the next edge, and resp_valid is suppressed, including when flush is sampled in DONE.
  - flush in the same cycle as req_valid in IDLE: no accept.
- Reset mid-operation aborts immediately; no response is produced.
- All arithmetic is XLEN-bit wrap-around. Negation is two's complement.

Optional Feature:
- Macro: MULDIV_OPCACHE_EN.
- When defined:
  - After each divide/remainder completes, retain a, b, signedness, quotient and remainder.
  - A later divide-family request with identical a, b and signedness (e.g. DIV followed by REM) goes IDLE -> DONE and returns the cached value with latency 1.
  - Cache is invalidated by reset, by flush, and by any accepted multiply.
- When undefined: no cache registers; every divide takes the full latency.

Decomposition:
- Package muldiv_pkg holds:
  - localparam op codes (OP_MUL ... OP_REMU).
  - typedef enum logic [2:0] muldiv_state_t {IDLE, MUL, DIV, FIX, DONE}.
  - XLEN default.
- Sub-module muldiv_div_step: combinational single restoring step (remainder, quotient, divisor -> next remainder, next quotient). Instantiated once inside muldiv_ctrl.

Test Plan:
- MUL a=7, b=-3 -> resp_data 0xFFFFFFEB 2 cycles after accept; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=-1, b=2 -> 0xFFFFFFFF.
- DIV a=-20, b=3 -> 0xFFFFFFFA at cycle 34; REM same operands -> 0xFFFFFFFE; stall high over cycles 1-33.
- DIVU a=5, b=0 -> 0xFFFFFFFF at latency 1; REM a=0x80000000, b=-1 -> 0; DIV same operands -> 0x80000000.
- Assert flush at cycle 10 of a DIV -> no resp_valid; req_ready high the next cycle; a new MUL is accepted and its result is correct.
- Assert rst mid-DIV, release, then issue DIVU 100/7 -> 14 with resp_rd matching req_rd.
- With MULDIV_OPCACHE_EN: DIV 100/7 then REM 100/7 -> second result 2 at latency 1; after an intervening MUL, REM takes latency 34.
